// File: rtl/fir_seq_ctrl_if.sv
// Control/coefficient bus between the FIR sequencer and its host/datapath.
// Signal names follow the block's established port names.
interface fir_seq_ctrl_if;
   logic        iStart;
   logic        iCoeffUpdate;
   logic        iCoeffValid;
   logic [15:0] iCoeffData;
   logic        oEnSample_600k;
   logic        oEnDelay;
   logic        oAccClr;
   logic        oMacEn;
   logic [3:0]  oMacAddr;
   logic        oSumEn;
   logic        oFirValid;
   logic        oCoeffWe;
   logic [5:0]  oCoeffAddr;
   logic [15:0] oCoeffData;
   logic        oCoeffLoaded;
   logic        oBusy;

   modport master (
      output iStart, iCoeffUpdate, iCoeffValid, iCoeffData,
      input  oEnSample_600k, oEnDelay, oAccClr, oMacEn, oMacAddr, oSumEn,
             oFirValid, oCoeffWe, oCoeffAddr, oCoeffData, oCoeffLoaded, oBusy
   );

   modport slave (
      input  iStart, iCoeffUpdate, iCoeffValid, iCoeffData,
      output oEnSample_600k, oEnDelay, oAccClr, oMacEn, oMacAddr, oSumEn,
             oFirValid, oCoeffWe, oCoeffAddr, oCoeffData, oCoeffLoaded, oBusy
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a 33-tap (3 x 11) FIR: coefficient load sessions and a
// 20-clock sample period schedule (600 kHz at 12 MHz).
//
// state | meaning
// IDLE  | waiting; coefficient update has priority over start
// LOAD  | accepting coefficient words into RAM addresses 0..32
// RUN   | continuous filtering, phase counter 0..19 per sample period
module fir_seq_ctrl (
   input  logic          iClk_12M,
   input  logic          iRsn,
   fir_seq_ctrl_if.slave bus
);

   localparam logic [5:0] LAST_ADDR    = 6'd32;
   localparam logic [4:0] LAST_PHASE   = 5'd19;
   localparam logic [4:0] PH_SAMPLE    = 5'd0;
   localparam logic [4:0] PH_ACC_CLR   = 5'd1;
   localparam logic [4:0] PH_MAC_FIRST = 5'd2;
   localparam logic [4:0] PH_MAC_LAST  = 5'd12;
   localparam logic [4:0] PH_SUM       = 5'd13;
   localparam logic [4:0] PH_VALID     = 5'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state_q, state_nx;
   logic [5:0]  wr_cnt_q, wr_cnt_nx;
   logic [4:0]  phase_q, phase_nx;
   logic        loaded_q, loaded_nx;

   logic        coeff_we_q, coeff_we_nx;
   logic [5:0]  coeff_addr_q, coeff_addr_nx;
   logic [15:0] coeff_data_q, coeff_data_nx;

   logic        en_sample_q, en_sample_nx;
   logic        en_delay_q, en_delay_nx;
   logic        acc_clr_q, acc_clr_nx;
   logic        mac_en_q, mac_en_nx;
   logic [3:0]  mac_addr_q, mac_addr_nx;
   logic        sum_en_q, sum_en_nx;
   logic        fir_valid_q, fir_valid_nx;
   logic        busy_q, busy_nx;
   logic        run_nx;

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         phase_q  <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_nx;
         wr_cnt_q <= wr_cnt_nx;
         phase_q  <= phase_nx;
         loaded_q <= loaded_nx;
      end
   end

   always_comb begin
      state_nx      = state_q;
      wr_cnt_nx     = wr_cnt_q;
      phase_nx      = phase_q;
      loaded_nx     = loaded_q;
      coeff_we_nx   = 1'b0;
      coeff_addr_nx = '0;
      coeff_data_nx = coeff_data_q;
      case (state_q)
         IDLE: begin
            if (bus.iCoeffUpdate) begin
               state_nx  = LOAD;
               wr_cnt_nx = '0;
               loaded_nx = 1'b0;
            end else if (bus.iStart && loaded_q) begin
               state_nx = RUN;
               phase_nx = '0;
            end
         end
         LOAD: begin
            // Dropping the update request abandons a partial set, even if a word arrives that cycle.
            if (!bus.iCoeffUpdate) begin
               state_nx  = IDLE;
               wr_cnt_nx = '0;
            end else if (bus.iCoeffValid) begin
               coeff_we_nx   = 1'b1;
               coeff_addr_nx = wr_cnt_q;
               coeff_data_nx = bus.iCoeffData;
               if (wr_cnt_q == LAST_ADDR) begin
                  state_nx  = IDLE;
                  wr_cnt_nx = '0;
                  loaded_nx = 1'b1;
               end else begin
                  wr_cnt_nx = wr_cnt_q + 6'd1;
               end
            end
         end
         RUN: begin
            if (phase_q == LAST_PHASE) begin
               phase_nx = '0;
               if (!bus.iStart) begin
                  state_nx = IDLE;
               end
            end else begin
               phase_nx = phase_q + 5'd1;
            end
         end
         default: begin
            state_nx  = IDLE;
            wr_cnt_nx = '0;
            phase_nx  = '0;
         end
      endcase
   end

   // Strobes are decoded from the next phase so the registered outputs line up with the phase they name.
   always_comb begin
      run_nx       = (state_nx == RUN);
      busy_nx      = (state_nx != IDLE);
      en_delay_nx  = run_nx;
      en_sample_nx = run_nx && (phase_nx == PH_SAMPLE);
      acc_clr_nx   = run_nx && (phase_nx == PH_ACC_CLR);
      mac_en_nx    = run_nx && (phase_nx >= PH_MAC_FIRST) && (phase_nx <= PH_MAC_LAST);
      sum_en_nx    = run_nx && (phase_nx == PH_SUM);
      fir_valid_nx = run_nx && (phase_nx == PH_VALID);
      mac_addr_nx  = '0;
      if (mac_en_nx) begin
         mac_addr_nx = 4'(phase_nx - PH_MAC_FIRST);
      end
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         coeff_we_q   <= 1'b0;
         coeff_addr_q <= '0;
         coeff_data_q <= '0;
         en_sample_q  <= 1'b0;
         en_delay_q   <= 1'b0;
         acc_clr_q    <= 1'b0;
         mac_en_q     <= 1'b0;
         mac_addr_q   <= '0;
         sum_en_q     <= 1'b0;
         fir_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         coeff_we_q   <= coeff_we_nx;
         coeff_addr_q <= coeff_addr_nx;
         coeff_data_q <= coeff_data_nx;
         en_sample_q  <= en_sample_nx;
         en_delay_q   <= en_delay_nx;
         acc_clr_q    <= acc_clr_nx;
         mac_en_q     <= mac_en_nx;
         mac_addr_q   <= mac_addr_nx;
         sum_en_q     <= sum_en_nx;
         fir_valid_q  <= fir_valid_nx;
         busy_q       <= busy_nx;
      end
   end

   assign bus.oEnSample_600k = en_sample_q;
   assign bus.oEnDelay       = en_delay_q;
   assign bus.oAccClr        = acc_clr_q;
   assign bus.oMacEn         = mac_en_q;
   assign bus.oMacAddr       = mac_addr_q;
   assign bus.oSumEn         = sum_en_q;
   assign bus.oFirValid      = fir_valid_q;
   assign bus.oCoeffWe       = coeff_we_q;
   assign bus.oCoeffAddr     = coeff_addr_q;
   assign bus.oCoeffData     = coeff_data_q;
   assign bus.oCoeffLoaded   = loaded_q;
   assign bus.oBusy          = busy_q;

endmodule
